// File: rtl/ram_ctrl_pkg.sv
// Shared command opcodes and controller state encoding for the RAM stream controller.
package ram_ctrl_pkg;
    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP,
        S_DRAIN,
        S_DONE
    } state_t;
endpackage

// File: rtl/ram_stream_out_reg.sv
// Two-word output register with valid/ready hold; reloads whenever empty or being consumed.
module ram_stream_out_reg #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] one_d,
    input  logic [N-1:0] two_d,
    input  logic         two_vld_d,
    input  logic         ready,
    output logic         valid,
    output logic [N-1:0] one,
    output logic [N-1:0] two,
    output logic         two_vld,
    output logic         load_en
);
    assign load_en = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            one     <= '0;
            two     <= '0;
            two_vld <= 1'b0;
        end else if (load_en) begin
            if (load) begin
                valid   <= 1'b1;
                one     <= one_d;
                two     <= two_d;
                two_vld <= two_vld_d;
            end else begin
                valid   <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ram_stream_controller.sv
// LOAD/DUMP command master for a 1W/2R RAM: streams words in one per cycle, out two per beat.
module ram_stream_controller
    import ram_ctrl_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 6000,
    parameter int K = 13
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         cmdValid,
    output logic         cmdReady,
    input  logic         cmdOp,
    input  logic [K-1:0] cmdBase,
    input  logic [K-1:0] cmdCount,
    output logic         cmdDone,
    output logic         cmdErr,
    input  logic         inValid,
    output logic         inReady,
    input  logic [N-1:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [N-1:0] outDataOne,
    output logic [N-1:0] outDataTwo,
    output logic         outTwoValid,
    output logic         WE,
    output logic [K-1:0] addressWritePort,
    output logic [N-1:0] writePortData,
    output logic [K-1:0] addressPortOne,
    output logic [K-1:0] addressPortTwo,
    input  logic [N-1:0] readPortOneData,
    input  logic [N-1:0] readPortTwoData
);
    localparam logic [K:0] DEPTH = (K+1)'(M);

    state_t       state, state_d;
    logic [K-1:0] ptr, rem;
    logic         err_q;
    logic         accept, range_bad, rem_ge2, load_en, dump_fire;
    logic [K:0]   end_addr;

    // Range check carries one extra bit so base+count cannot wrap past the depth.
    assign end_addr  = {1'b0, cmdBase} + {1'b0, cmdCount};
    assign range_bad = end_addr > DEPTH;
    assign accept    = cmdValid && (state == S_IDLE);
    assign rem_ge2   = rem >= K'(2);
    assign dump_fire = (state == S_DUMP) && load_en;
    assign cmdErr    = err_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            rem   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            err_q <= accept && range_bad;
            if (accept && !range_bad) begin
                ptr <= cmdBase;
                rem <= cmdCount;
            end else if (WE) begin
                ptr <= ptr + K'(1);
                rem <= rem - K'(1);
            end else if (dump_fire) begin
                ptr <= ptr + K'(2);
                rem <= rem - (rem_ge2 ? K'(2) : rem);
            end
        end
    end

    always_comb begin
        state_d          = state;
        cmdReady         = 1'b0;
        cmdDone          = 1'b0;
        inReady          = 1'b0;
        WE               = 1'b0;
        addressWritePort = '0;
        writePortData    = '0;
        addressPortOne   = '0;
        addressPortTwo   = '0;
        case (state)
            S_IDLE: begin
                cmdReady = 1'b1;
                if (accept && !range_bad) begin
                    if (cmdCount == '0)        state_d = S_DONE;
                    else if (cmdOp == OP_DUMP) state_d = S_DUMP;
                    else                       state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                inReady          = 1'b1;
                WE               = inValid;
                addressWritePort = ptr;
                writePortData    = inData;
                if (inValid && rem == K'(1)) state_d = S_DONE;
            end
            S_DUMP: begin
                // Second port stays on ptr for a lone final word so it never reads past the end.
                addressPortOne = ptr;
                addressPortTwo = rem_ge2 ? ptr + K'(1) : ptr;
                if (load_en && rem <= K'(2)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (outValid && outReady) state_d = S_DONE;
            end
            S_DONE: begin
                cmdDone = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    ram_stream_out_reg #(.N(N)) u_out_reg (
        .clk      (Clk),
        .rst      (Rst),
        .load     (dump_fire),
        .one_d    (readPortOneData),
        .two_d    (readPortTwoData),
        .two_vld_d(rem_ge2),
        .ready    (outReady),
        .valid    (outValid),
        .one      (outDataOne),
        .two      (outDataTwo),
        .two_vld  (outTwoValid),
        .load_en  (load_en)
    );
endmodule

// File: tb/tb_ram_stream_controller.sv
// Directed bench: behavioural 1W/2R RAM plus a scoreboard of expected DUMP beats.
module tb_ram_stream_controller;
    import ram_ctrl_pkg::*;

    localparam int N = 16;
    localparam int M = 6000;
    localparam int K = 13;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         cmdValid = 1'b0, cmdOp = 1'b0;
    logic [K-1:0] cmdBase = '0, cmdCount = '0;
    logic         cmdReady, cmdDone, cmdErr;
    logic         inValid = 1'b0, inReady;
    logic [N-1:0] inData = '0;
    logic         outValid, outReady = 1'b0, outTwoValid;
    logic [N-1:0] outDataOne, outDataTwo;
    logic         WE;
    logic [K-1:0] addressWritePort, addressPortOne, addressPortTwo;
    logic [N-1:0] writePortData, readPortOneData, readPortTwoData;

    logic [N-1:0] mem     [0:M-1];
    logic [N-1:0] exp_mem [0:M-1];
    logic         clr = 1'b1;

    typedef struct {
        logic [N-1:0] one;
        logic [N-1:0] two;
        logic         tv;
    } beat_t;
    beat_t sb[$];

    int vectors = 0, miscompares = 0, beats = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (clr) begin
            for (int i = 0; i < M; i++) mem[i] <= '0;
        end else if (WE) begin
            mem[addressWritePort] <= writePortData;
        end
    end
    assign readPortOneData = mem[addressPortOne];
    assign readPortTwoData = mem[addressPortTwo];

    ram_stream_controller #(.N(N), .M(M), .K(K)) dut (
        .Clk(Clk), .Rst(Rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdBase(cmdBase), .cmdCount(cmdCount), .cmdDone(cmdDone), .cmdErr(cmdErr),
        .inValid(inValid), .inReady(inReady), .inData(inData),
        .outValid(outValid), .outReady(outReady),
        .outDataOne(outDataOne), .outDataTwo(outDataTwo), .outTwoValid(outTwoValid),
        .WE(WE), .addressWritePort(addressWritePort), .writePortData(writePortData),
        .addressPortOne(addressPortOne), .addressPortTwo(addressPortTwo),
        .readPortOneData(readPortOneData), .readPortTwoData(readPortTwoData)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: stall stability and in-order beat comparison against the scoreboard.
    logic         stall_prev = 1'b0;
    logic [N-1:0] h1, h2;
    logic         htv;
    always @(negedge Clk) begin
        beat_t e;
        if (stall_prev && !Rst) begin
            check("hold_valid", outValid, 1);
            check("hold_one", outDataOne, h1);
            check("hold_two", outDataTwo, h2);
            check("hold_tv", outTwoValid, htv);
        end
        if (outValid && outReady) begin
            beats++;
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check("beat_one", outDataOne, e.one);
                check("beat_tv", outTwoValid, e.tv);
                if (e.tv) check("beat_two", outDataTwo, e.two);
            end
        end
        stall_prev = outValid && !outReady;
        h1 = outDataOne;
        h2 = outDataTwo;
        htv = outTwoValid;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic op, input int base, input int count);
        int w = 0;
        while (!cmdReady && w < 50) begin
            tick();
            w++;
        end
        check("cmd_ready", cmdReady, 1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdBase  = K'(base);
        cmdCount = K'(count);
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic do_load(input int base, input int n, input int seed,
                           input logic [15:0] pat, input bit poke);
        int idx = 0;
        int step = 0;
        issue(OP_LOAD, base, n);
        if (poke) begin
            cmdValid = 1'b1;
            cmdOp    = OP_DUMP;
            cmdBase  = '0;
            cmdCount = K'(1);
        end
        while (idx < n && step < 64) begin
            inValid = (step < 16) ? pat[step] : 1'b1;
            inData  = N'(seed + idx);
            #1;
            check("ld_in_ready", inReady, 1);
            check("ld_we", WE, inValid);
            if (poke) check("busy_cmd_ready", cmdReady, 0);
            if (inValid) begin
                check("ld_addr", addressWritePort, base + idx);
                check("ld_wdata", writePortData, seed + idx);
            end
            tick();
            if (inValid) begin
                exp_mem[base + idx] = N'(seed + idx);
                idx++;
            end
            step++;
        end
        inValid  = 1'b0;
        cmdValid = 1'b0;
        check("ld_done_pulse", cmdDone, 1);
        check("ld_we_after", WE, 0);
        tick();
        check("ld_done_clear", cmdDone, 0);
        check("ld_ready_back", cmdReady, 1);
        for (int i = 0; i < n; i++) check("ld_mem", mem[base + i], exp_mem[base + i]);
    endtask

    task automatic do_dump(input int base, input int count, input bit bp);
        int b0;
        int rem;
        int a;
        int found = 0;
        beat_t e;
        a = base;
        rem = count;
        while (rem > 0) begin
            e.one = exp_mem[a];
            e.tv  = (rem >= 2);
            e.two = e.tv ? exp_mem[a + 1] : '0;
            sb.push_back(e);
            a += 2;
            rem -= (rem >= 2) ? 2 : 1;
        end
        b0 = beats;
        issue(OP_DUMP, base, count);
        check("dump_a1", addressPortOne, base);
        check("dump_a2", addressPortTwo, (count >= 2) ? base + 1 : base);
        check("dump_first_not_yet", outValid, 0);
        for (int c = 0; c < 200 && found == 0; c++) begin
            outReady = bp ? (c % 3 == 0) : 1'b1;
            tick();
            if (c == 0) check("dump_first_valid", outValid, 1);
            if (cmdDone) found = 1;
        end
        outReady = 1'b0;
        check("dump_done_seen", found, 1);
        tick();
        check("dump_done_clear", cmdDone, 0);
        check("dump_beats", beats - b0, (count + 1) / 2);
        check("dump_sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        for (int i = 0; i < M; i++) exp_mem[i] = '0;

        #1;
        check("rst_cmd_ready", cmdReady, 1);
        check("rst_out_valid", outValid, 0);
        check("rst_we", WE, 0);
        check("rst_done", cmdDone, 0);
        check("rst_err", cmdErr, 0);
        check("rst_out_one", outDataOne, 0);
        tick();
        tick();
        clr = 1'b0;
        Rst = 1'b0;
        tick();

        // LOAD 0..4 with 10..14 back-to-back, then read back two words per beat.
        do_load(0, 5, 10, 16'hFFFF, 1'b0);
        do_dump(0, 5, 1'b0);

        // Top-of-memory reads.
        do_load(5998, 2, 16'hA5A5, 16'hFFFF, 1'b0);
        do_dump(5998, 2, 1'b0);
        do_dump(5999, 1, 1'b0);

        // Out-of-range command is rejected without touching the RAM.
        issue(OP_DUMP, 5999, 2);
        check("err_pulse", cmdErr, 1);
        check("err_stay_idle", cmdReady, 1);
        check("err_we", WE, 0);
        check("err_addr1", addressPortOne, 0);
        check("err_no_out", outValid, 0);
        tick();
        check("err_clear", cmdErr, 0);
        check("err_no_done", cmdDone, 0);

        // LOAD with input gaps while a second command is held on the bus, then backpressured DUMP.
        do_load(40, 4, 16'h0100, 16'h0035, 1'b1);
        do_dump(40, 6, 1'b1);

        // Zero-length command completes without a write.
        issue(OP_LOAD, 100, 0);
        found = 0;
        for (int c = 0; c < 2 && found == 0; c++) begin
            check("zero_we", WE, 0);
            if (cmdDone) found = 1;
            else tick();
        end
        check("zero_done_seen", found, 1);
        tick();
        check("zero_done_clear", cmdDone, 0);
        check("zero_ready", cmdReady, 1);

        // Reset in the middle of a LOAD aborts it immediately.
        issue(OP_LOAD, 200, 4);
        for (int i = 0; i < 2; i++) begin
            inValid = 1'b1;
            inData  = N'(16'h0C00 + i);
            tick();
        end
        inData = 16'hBEEF;
        #1;
        Rst = 1'b1;
        #1;
        check("arst_we", WE, 0);
        check("arst_waddr", addressWritePort, 0);
        check("arst_wdata", writePortData, 0);
        check("arst_cmd_ready", cmdReady, 1);
        check("arst_in_ready", inReady, 0);
        check("arst_out_valid", outValid, 0);
        check("arst_done", cmdDone, 0);
        tick();
        Rst = 1'b0;
        tick();
        inValid = 1'b0;
        tick();
        check("arst_mem_w0", mem[200], 16'h0C00);
        check("arst_mem_w1", mem[201], 16'h0C01);
        check("arst_mem_w2", mem[202], 0);
        check("arst_idle", cmdReady, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
